// File: rtl/v_fp_pkg.sv
// Shared definitions for the vector FP LUT/min-max-sign-injection unit.
//   - microop encodings for the LUT class (VTAN/VSIN/VCOS) and the short class
//     (VFMIN/VFMAX/VFSGNJ/VFSGNJN/VFSGNJX)
//   - canonical quiet NaN returned when both min/max operands are NaN
//   - pipe_entry_t: per-stage bookkeeping carried alongside the data
//   - helpers that classify microops and compute one lane of a short op
package v_fp_pkg;

  localparam int unsigned V_LANES         = 4;
  localparam int unsigned V_TICKET_BITS   = 5;
  localparam int unsigned V_MICROOP_WIDTH = 7;

  localparam logic [6:0] VTAN    = 7'h20;
  localparam logic [6:0] VSIN    = 7'h21;
  localparam logic [6:0] VCOS    = 7'h22;
  localparam logic [6:0] VFMIN   = 7'h23;
  localparam logic [6:0] VFMAX   = 7'h24;
  localparam logic [6:0] VFSGNJ  = 7'h25;
  localparam logic [6:0] VFSGNJN = 7'h26;
  localparam logic [6:0] VFSGNJX = 7'h27;

  localparam logic [31:0] FP_CANON_NAN = 32'h7FC0_0000;

  typedef struct packed {
    logic                       valid;
    logic [V_TICKET_BITS-1:0]   ticket;
    logic [V_LANES-1:0]         mask;
    logic [V_MICROOP_WIDTH-1:0] microop;
  } pipe_entry_t;

  function automatic logic is_lut_op(input logic [6:0] op);
    return (op == VTAN) || (op == VSIN) || (op == VCOS);
  endfunction

  function automatic logic is_short_op(input logic [6:0] op);
    return (op == VFMIN) || (op == VFMAX) || (op == VFSGNJ) || (op == VFSGNJN) ||
           (op == VFSGNJX);
  endfunction

  function automatic logic fp_is_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

  // Strict less-than on non-NaN values; sign-magnitude order puts -0 below +0.
  function automatic logic fp_lt(input logic [31:0] a, input logic [31:0] b);
    if (a[31] != b[31]) begin
      return a[31];
    end
    if (a[31]) begin
      return a[30:0] > b[30:0];
    end
    return a[30:0] < b[30:0];
  endfunction

  function automatic logic [31:0] fp_short(input logic [6:0]  op,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
    logic [31:0] res;
    logic        a_nan;
    logic        b_nan;
    res   = '0;
    a_nan = fp_is_nan(a);
    b_nan = fp_is_nan(b);
    case (op)
      VFMIN, VFMAX: begin
        if (a_nan && b_nan) begin
          res = FP_CANON_NAN;
        end else if (a_nan) begin
          res = b;
        end else if (b_nan) begin
          res = a;
        end else if (op == VFMIN) begin
          res = fp_lt(b, a) ? b : a;
        end else begin
          res = fp_lt(a, b) ? b : a;
        end
      end
      VFSGNJ:  res = {b[31], a[30:0]};
      VFSGNJN: res = {~b[31], a[30:0]};
      VFSGNJX: res = {a[31] ^ b[31], a[30:0]};
      default: res = '0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/v_fp_lut_bank.sv
// Three function tables (TAN, SIN, COS) of 2**ADDR_W entries each.
//   clk_i      clock
//   we_i       write strobe; sel_i picks the table (3 = no write)
//   addr_i     write entry, wdata_i write value (visible after the edge)
//   rd_en_i    read enable for all lanes
//   rd_sel_i   table read by every lane (0=TAN 1=SIN 2=COS)
//   rd_idx_i   per-lane entry index, lane k = [k*ADDR_W +: ADDR_W]
//   rd_data_o  registered per-lane read data, lane k = [k*DATA_WIDTH +: DATA_WIDTH]
// Contents are intentionally not reset.
module v_fp_lut_bank #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LANES      = 4,
  parameter int unsigned ADDR_W     = 6
) (
  input  logic                        clk_i,
  input  logic                        we_i,
  input  logic [1:0]                  sel_i,
  input  logic [ADDR_W-1:0]           addr_i,
  input  logic [DATA_WIDTH-1:0]       wdata_i,
  input  logic                        rd_en_i,
  input  logic [1:0]                  rd_sel_i,
  input  logic [LANES*ADDR_W-1:0]     rd_idx_i,
  output logic [LANES*DATA_WIDTH-1:0] rd_data_o
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  logic [DATA_WIDTH-1:0]       tan_q [Depth];
  logic [DATA_WIDTH-1:0]       sin_q [Depth];
  logic [DATA_WIDTH-1:0]       cos_q [Depth];
  logic [LANES*DATA_WIDTH-1:0] rd_data_q;

  // Non-blocking write and read in one block: a read of the entry being
  // written in the same cycle returns the old contents.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      case (sel_i)
        2'd0:    tan_q[addr_i] <= wdata_i;
        2'd1:    sin_q[addr_i] <= wdata_i;
        2'd2:    cos_q[addr_i] <= wdata_i;
        default: ;
      endcase
    end
    if (rd_en_i) begin
      for (int k = 0; k < int'(LANES); k++) begin
        case (rd_sel_i)
          2'd0:    rd_data_q[k*DATA_WIDTH +: DATA_WIDTH] <= tan_q[rd_idx_i[k*ADDR_W +: ADDR_W]];
          2'd1:    rd_data_q[k*DATA_WIDTH +: DATA_WIDTH] <= sin_q[rd_idx_i[k*ADDR_W +: ADDR_W]];
          default: rd_data_q[k*DATA_WIDTH +: DATA_WIDTH] <= cos_q[rd_idx_i[k*ADDR_W +: ADDR_W]];
        endcase
      end
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/v_fp_lut_pipe.sv
// Multi-lane vector FP unit: LUT-based VTAN/VSIN/VCOS (3-cycle latency) and
// VFMIN/VFMAX/VFSGNJ* (1-cycle latency) sharing one issue and one result port.
//   clk, rst_n              clock, synchronous active-low reset
//   valid_i/ready_o         issue handshake; microop_i, ticket_i, mask_i per issue
//   data_a_i, data_b_i      operands, lane k = [k*32 +: 32]
//   flush_i                 kills everything in flight and any same-cycle issue
//   lut_we_i/sel/addr/wdata table programming port
//   valid_o, ticket_o       one-cycle completion pulse with the op's tag
//   result_o                per-lane result, masked lanes = 0
//   illegal_o               pulse one cycle after an unknown microop is accepted
//   busy_o                  a LUT op is still in S1 or S2
module v_fp_lut_pipe
  import v_fp_pkg::*;
#(
  parameter int unsigned DATA_WIDTH         = 32,
  parameter int unsigned VECTOR_LANE_NUM    = V_LANES,
  parameter int unsigned MICROOP_WIDTH      = V_MICROOP_WIDTH,
  parameter int unsigned VECTOR_TICKET_BITS = V_TICKET_BITS,
  parameter int unsigned LUT_ADDR_W         = 6
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  valid_i,
  output logic                                  ready_o,
  input  logic [MICROOP_WIDTH-1:0]              microop_i,
  input  logic [VECTOR_TICKET_BITS-1:0]         ticket_i,
  input  logic [VECTOR_LANE_NUM*DATA_WIDTH-1:0] data_a_i,
  input  logic [VECTOR_LANE_NUM*DATA_WIDTH-1:0] data_b_i,
  input  logic [VECTOR_LANE_NUM-1:0]            mask_i,
  input  logic                                  flush_i,
  input  logic                                  lut_we_i,
  input  logic [1:0]                            lut_sel_i,
  input  logic [LUT_ADDR_W-1:0]                 lut_addr_i,
  input  logic [DATA_WIDTH-1:0]                 lut_wdata_i,
  output logic                                  valid_o,
  output logic [VECTOR_TICKET_BITS-1:0]         ticket_o,
  output logic [VECTOR_LANE_NUM*DATA_WIDTH-1:0] result_o,
  output logic                                  illegal_o,
  output logic                                  busy_o
);

  localparam int unsigned Lanes = VECTOR_LANE_NUM;
  localparam int unsigned Dw    = DATA_WIDTH;
  localparam int unsigned Aw    = LUT_ADDR_W;

  if (DATA_WIDTH != 32) begin : g_chk_dw
    $error("v_fp_lut_pipe: only IEEE single (DATA_WIDTH = 32) is supported");
  end
  if (VECTOR_LANE_NUM != V_LANES || MICROOP_WIDTH != V_MICROOP_WIDTH ||
      VECTOR_TICKET_BITS != V_TICKET_BITS) begin : g_chk_pkg
    $error("v_fp_lut_pipe: lane/microop/ticket widths must match v_fp_pkg");
  end

  pipe_entry_t            s1_d, s1_q, s2_d, s2_q;
  logic [Lanes*Aw-1:0]    s1_idx_d, s1_idx_q;
  logic [Lanes-1:0]       s1_sgn_d, s1_sgn_q, s2_sgn_q;
  logic [Lanes*Dw-1:0]    lut_rd_data;
  logic [Lanes*Dw-1:0]    lut_res, short_res;
  logic                   valid_d, valid_q;
  logic [VECTOR_TICKET_BITS-1:0] ticket_d, ticket_q;
  logic [Lanes*Dw-1:0]    result_d, result_q;
  logic                   illegal_d, illegal_q;
  logic                   op_lut, op_short, accept;

  assign op_lut   = is_lut_op(microop_i);
  assign op_short = is_short_op(microop_i);
  // A short op issued now would complete in the same cycle as the LUT op in S2.
  assign ready_o  = ~(s2_q.valid & op_short);
  assign accept   = valid_i & ready_o & ~flush_i;
  assign busy_o   = s1_q.valid | s2_q.valid;

  // S1: capture table index (|a| exponent/mantissa MSBs) and the sign of a.
  always_comb begin
    s1_d.valid   = accept & op_lut;
    s1_d.ticket  = ticket_i;
    s1_d.mask    = mask_i;
    s1_d.microop = microop_i;
    s1_idx_d     = '0;
    s1_sgn_d     = '0;
    for (int k = 0; k < int'(Lanes); k++) begin
      s1_idx_d[k*Aw +: Aw] = data_a_i[k*Dw + 30 -: Aw];
      s1_sgn_d[k]          = data_a_i[k*Dw + 31];
    end
  end

  // S2: table read happens in the bank; bookkeeping follows it here.
  always_comb begin
    s2_d       = s1_q;
    s2_d.valid = s1_q.valid & ~flush_i;
  end

  v_fp_lut_bank #(
    .DATA_WIDTH (Dw),
    .LANES      (Lanes),
    .ADDR_W     (Aw)
  ) u_lut_bank (
    .clk_i     (clk),
    .we_i      (lut_we_i),
    .sel_i     (lut_sel_i),
    .addr_i    (lut_addr_i),
    .wdata_i   (lut_wdata_i),
    .rd_en_i   (s1_q.valid),
    .rd_sel_i  (s1_q.microop[1:0]),
    .rd_idx_i  (s1_idx_q),
    .rd_data_o (lut_rd_data)
  );

  // S3 data: COS is even so it keeps the entry sign; TAN and SIN are odd.
  always_comb begin
    logic [Dw-1:0] entry;
    entry   = '0;
    lut_res = '0;
    for (int k = 0; k < int'(Lanes); k++) begin
      entry = lut_rd_data[k*Dw +: Dw];
      if (s2_q.mask[k]) begin
        lut_res[k*Dw +: Dw] = {entry[31] ^ (s2_sgn_q[k] & (s2_q.microop != VCOS)),
                               entry[30:0]};
      end
    end
  end

  always_comb begin
    short_res = '0;
    for (int k = 0; k < int'(Lanes); k++) begin
      if (mask_i[k]) begin
        short_res[k*Dw +: Dw] = fp_short(microop_i, data_a_i[k*Dw +: Dw],
                                         data_b_i[k*Dw +: Dw]);
      end
    end
  end

  // Writeback: the ready_o stall guarantees the two sources never coincide.
  always_comb begin
    valid_d   = 1'b0;
    ticket_d  = ticket_q;
    result_d  = result_q;
    illegal_d = accept & ~op_lut & ~op_short;
    if (!flush_i) begin
      if (s2_q.valid) begin
        valid_d  = 1'b1;
        ticket_d = s2_q.ticket;
        result_d = lut_res;
      end else if (accept && op_short) begin
        valid_d  = 1'b1;
        ticket_d = ticket_i;
        result_d = short_res;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q      <= '0;
      s2_q      <= '0;
      s1_idx_q  <= '0;
      s1_sgn_q  <= '0;
      s2_sgn_q  <= '0;
      valid_q   <= 1'b0;
      ticket_q  <= '0;
      result_q  <= '0;
      illegal_q <= 1'b0;
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      s1_idx_q  <= s1_idx_d;
      s1_sgn_q  <= s1_sgn_d;
      s2_sgn_q  <= s1_sgn_q;
      valid_q   <= valid_d;
      ticket_q  <= ticket_d;
      result_q  <= result_d;
      illegal_q <= illegal_d;
    end
  end

  assign valid_o   = valid_q;
  assign ticket_o  = ticket_q;
  assign result_o  = result_q;
  assign illegal_o = illegal_q;

endmodule
